// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed N-digit 7-segment driver. A packed nibble vector and
// per-digit decimal points are double-buffered, decoded (decimal or hex)
// and scanned onto one shared segment bus plus N digit enables. It also
// provides leading-zero blanking, an anti-ghost guard window at the start
// of every digit slot, and independent output polarities for segments
// and anodes.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2,
  parameter int HEX_EN      = 1,
  parameter int LZ_BLANK    = 1,
  parameter int SEG_ACT_LOW = 0,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  load,
  input  logic [4*NUM_DIGITS-1:0]                               value,
  input  logic [NUM_DIGITS-1:0]                                 dp_in,
  input  logic                                                  blank_in,
  output logic [7:0]                                            seg,
  output logic [NUM_DIGITS-1:0]                                 an,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
  output logic                                                  frame_done
);

  localparam int DIGW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [DIGW-1:0]       DIG_LAST   = DIGW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [31:0]           GUARD_U    = 32'(GUARD);
  localparam logic [7:0]            SEG_OFF    = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = (AN_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                   : {NUM_DIGITS{1'b0}};

  // Scan timing state
  logic [PW-1:0]           presc_q, presc_d;
  logic [DIGW-1:0]         digit_q, digit_d;
  logic                    frame_done_q, frame_done_d;

  // Double buffer: pending is written by load, display only on frame wrap
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;

  // Registered pin drivers
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  // Decode helpers
  logic                    tc;
  logic                    wrap;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic [NUM_DIGITS-1:0]   digit_zero;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    in_guard;
  logic [7:0]              seg_pat;
  logic [NUM_DIGITS-1:0]   an_active;

  // Active-high segment pattern {a,b,c,d,e,f,g,dp} for one nibble, dp clear
  function automatic logic [7:0] decode_nib(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0:    pat = 8'hFC;
      4'h1:    pat = 8'h60;
      4'h2:    pat = 8'hDA;
      4'h3:    pat = 8'hF2;
      4'h4:    pat = 8'h66;
      4'h5:    pat = 8'hB6;
      4'h6:    pat = 8'hBE;
      4'h7:    pat = 8'hE0;
      4'h8:    pat = 8'hFE;
      4'h9:    pat = 8'hF6;
      4'hA:    pat = 8'hEE;
      4'hB:    pat = 8'h3E;
      4'hC:    pat = 8'h9C;
      4'hD:    pat = 8'h7A;
      4'hE:    pat = 8'h9E;
      default: pat = 8'h8E;
    endcase
    // Without hex support anything above 9 is shown as a single dash
    if ((HEX_EN == 0) && (nib > 4'h9)) begin
      pat = 8'h02;
    end
    return pat;
  endfunction

  // Per-digit one-hot select of the scanned digit and "this digit is an
  // empty zero" flag (zero nibble with its decimal point off)
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_sel[gi]  = (digit_q == DIGW'(gi));
      assign digit_zero[gi] = (disp_val_q[4*gi +: 4] == 4'h0) && !disp_dp_q[gi];
    end
  endgenerate

  // Leading-zero mask: a digit is blanked when it and every digit above it
  // are empty zeros; the rightmost digit always stays visible
  always_comb begin
    logic run;
    run     = 1'b1;
    lz_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run        = run & digit_zero[k];
      lz_mask[k] = run;
    end
    lz_mask[0] = 1'b0;
    if (LZ_BLANK == 0) begin
      lz_mask = '0;
    end
  end

  // Pick the nibble, dp and blanking state of the digit being scanned
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_sel[k]) begin
        cur_nib = disp_val_q[4*k +: 4];
        cur_dp  = disp_dp_q[k];
      end
    end
    cur_blank = |(digit_sel & lz_mask);
  end

  // Prescaler, digit index and double-buffer next state
  always_comb begin
    presc_d      = presc_q;
    digit_d      = digit_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_flag_d  = pend_flag_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;

    tc           = (presc_q == PRESC_LAST);
    wrap         = tc && (digit_q == DIG_LAST);
    frame_done_d = wrap;

    if (tc) begin
      presc_d = '0;
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    if (wrap) begin
      // A load coinciding with the wrap bypasses pending so it is not lost
      // for a whole frame; otherwise publish whatever is pending
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
      end else if (pend_flag_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
      pend_flag_d = 1'b0;
    end else if (load) begin
      pend_val_d  = value;
      pend_dp_d   = dp_in;
      pend_flag_d = 1'b1;
    end
  end

  // Output pattern and anode enables for the current scan state
  always_comb begin
    in_guard  = (32'(presc_q) < GUARD_U);
    seg_pat   = cur_blank ? 8'h00 : (decode_nib(cur_nib) | {7'b0, cur_dp});
    an_active = (in_guard || blank_in) ? '0 : digit_sel;
    seg_d     = (SEG_ACT_LOW != 0) ? ~seg_pat : seg_pat;
    an_d      = (AN_ACT_LOW != 0) ? ~an_active : an_active;
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      digit_q      <= '0;
      frame_done_q <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
    end else begin
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      frame_done_q <= frame_done_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign digit_idx  = digit_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 4 clocks per slot,
// 1-cycle guard. A second instance with hex decode disabled runs in
// lockstep on the same inputs.
module tb_seg7_scan_driver;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        load     = 1'b0;
  logic        blank_in = 1'b0;
  logic [15:0] value    = 16'h0000;
  logic [3:0]  dp_in    = 4'h0;

  logic [7:0]  seg, seg_nh;
  logic [3:0]  an, an_nh;
  logic [1:0]  digit_idx, didx_nh;
  logic        frame_done, fd_nh;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;   // clock edges since the last reset release

  seg7_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .HEX_EN(1),
    .LZ_BLANK(1), .SEG_ACT_LOW(0), .AN_ACT_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .seg(seg), .an(an), .digit_idx(digit_idx),
    .frame_done(frame_done)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .HEX_EN(0),
    .LZ_BLANK(1), .SEG_ACT_LOW(0), .AN_ACT_LOW(1)
  ) dut_nh (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .seg(seg_nh), .an(an_nh), .digit_idx(didx_nh),
    .frame_done(fd_nh)
  );

  always #5 clk = ~clk;

  // One clock: inputs are set at the falling edge, outputs read there too
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Advance until the internal state sits at frame phase ph (digit*4+presc)
  task automatic goto_state(input int ph);
    for (int n = 0; n < 16 && (cyc % 16) != ph; n++) step();
  endtask

  // Advance until the registered outputs reflect digit d, prescaler p
  task automatic goto_out(input int d, input int p);
    for (int n = 0; n < 16 && ((cyc + 15) % 16) != (d * 4 + p); n++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    $display("load value=%h dp=%b at phase %0d", v, dp, cyc % 16);
    value = v;
    dp_in = dp;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    int o;
    $display("test_reset");
    repeat (3) @(negedge clk);
    vectors++; if (seg !== 8'h00) begin miscompares++; $display("FAIL rst_seg: got %h want 00", seg); end
    vectors++; if (an !== 4'hF) begin miscompares++; $display("FAIL rst_an: got %b want 1111", an); end
    vectors++; if (digit_idx !== 2'd0) begin miscompares++; $display("FAIL rst_idx: got %0d want 0", digit_idx); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_fd: got %b want 0", frame_done); end
    rst = 1'b0;
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      o = (cyc + 15) % 16;
      exp_an = 4'hF;
      if ((o % 4) != 0) exp_an[o / 4] = 1'b0;
      exp_seg = ((o / 4) == 0) ? 8'hFC : 8'h00;
      vectors++; if (digit_idx !== 2'((cyc / 4) % 4)) begin miscompares++; $display("FAIL walk_idx c%0d: got %0d want %0d", cyc, digit_idx, (cyc / 4) % 4); end
      vectors++; if (frame_done !== ((cyc % 16) == 0)) begin miscompares++; $display("FAIL walk_fd c%0d: got %b", cyc, frame_done); end
      vectors++; if (an !== exp_an) begin miscompares++; $display("FAIL walk_an c%0d: got %b want %b", cyc, an, exp_an); end
      vectors++; if (seg !== exp_seg) begin miscompares++; $display("FAIL walk_seg c%0d: got %h want %h", cyc, seg, exp_seg); end
    end
  endtask

  task automatic test_double_buffer();
    $display("test_double_buffer");
    goto_state(5);
    do_load(16'h1A3F, 4'b0000);
    goto_out(2, 2);
    vectors++; if (seg !== 8'h00) begin miscompares++; $display("FAIL hold_d2: got %h want 00", seg); end
    goto_out(3, 2);
    vectors++; if (seg !== 8'h00) begin miscompares++; $display("FAIL hold_d3: got %h want 00", seg); end
    vectors++; if (an !== 4'b0111) begin miscompares++; $display("FAIL hold_an3: got %b want 0111", an); end
    goto_out(0, 2);
    vectors++; if (seg !== 8'h8E) begin miscompares++; $display("FAIL new_d0: got %h want 8E", seg); end
    vectors++; if (an !== 4'b1110) begin miscompares++; $display("FAIL new_an0: got %b want 1110", an); end
    goto_out(1, 2);
    vectors++; if (seg !== 8'hF2) begin miscompares++; $display("FAIL new_d1: got %h want F2", seg); end
    goto_out(2, 2);
    vectors++; if (seg !== 8'hEE) begin miscompares++; $display("FAIL new_d2: got %h want EE", seg); end
    vectors++; if (an !== 4'b1011) begin miscompares++; $display("FAIL new_an2: got %b want 1011", an); end
    goto_out(3, 2);
    vectors++; if (seg !== 8'h60) begin miscompares++; $display("FAIL new_d3: got %h want 60", seg); end
  endtask

  task automatic test_lz_blank();
    $display("test_lz_blank");
    goto_state(2);
    do_load(16'h0050, 4'b0000);
    goto_state(0);
    goto_out(0, 2);
    vectors++; if (seg !== 8'hFC) begin miscompares++; $display("FAIL lz_d0: got %h want FC", seg); end
    goto_out(1, 2);
    vectors++; if (seg !== 8'hB6) begin miscompares++; $display("FAIL lz_d1: got %h want B6", seg); end
    goto_out(2, 2);
    vectors++; if (seg !== 8'h00) begin miscompares++; $display("FAIL lz_d2: got %h want 00", seg); end
    vectors++; if (an !== 4'b1011) begin miscompares++; $display("FAIL lz_an2: got %b want 1011", an); end
    goto_out(3, 2);
    vectors++; if (seg !== 8'h00) begin miscompares++; $display("FAIL lz_d3: got %h want 00", seg); end
    vectors++; if (an !== 4'b0111) begin miscompares++; $display("FAIL lz_an3: got %b want 0111", an); end
    goto_state(3);
    do_load(16'h0050, 4'b1000);
    goto_state(0);
    goto_out(2, 0);
    vectors++; if (seg !== 8'hFC) begin miscompares++; $display("FAIL guard_seg2: got %h want FC", seg); end
    vectors++; if (an !== 4'hF) begin miscompares++; $display("FAIL guard_an2: got %b want 1111", an); end
    goto_out(3, 2);
    vectors++; if (seg !== 8'hFD) begin miscompares++; $display("FAIL dp_d3: got %h want FD", seg); end
  endtask

  task automatic test_back_to_back();
    $display("test_back_to_back");
    goto_state(5);
    do_load(16'h1111, 4'b0000);
    goto_state(9);
    do_load(16'h2222, 4'b0000);
    goto_state(0);
    goto_out(0, 2);
    vectors++; if (seg !== 8'hDA) begin miscompares++; $display("FAIL b2b_d0: got %h want DA", seg); end
    goto_out(3, 2);
    vectors++; if (seg !== 8'hDA) begin miscompares++; $display("FAIL b2b_d3: got %h want DA", seg); end
    // state is now at the wrap cycle (digit 3, last prescaler count)
    do_load(16'h0007, 4'b0000);
    goto_out(0, 2);
    vectors++; if (seg !== 8'hE0) begin miscompares++; $display("FAIL wrapload_d0: got %h want E0", seg); end
    goto_out(1, 2);
    vectors++; if (seg !== 8'h00) begin miscompares++; $display("FAIL wrapload_d1: got %h want 00", seg); end
    goto_out(3, 2);
    vectors++; if (an !== 4'b0111) begin miscompares++; $display("FAIL wrapload_an3: got %b want 0111", an); end
  endtask

  task automatic test_blank_in();
    $display("test_blank_in");
    goto_state(10);
    blank_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      vectors++; if (an !== 4'hF) begin miscompares++; $display("FAIL blank_an c%0d: got %b want 1111", cyc, an); end
      vectors++; if (digit_idx !== 2'((cyc / 4) % 4)) begin miscompares++; $display("FAIL blank_idx c%0d: got %0d want %0d", cyc, digit_idx, (cyc / 4) % 4); end
      vectors++; if (frame_done !== ((cyc % 16) == 0)) begin miscompares++; $display("FAIL blank_fd c%0d: got %b", cyc, frame_done); end
    end
    blank_in = 1'b0;
    step();
    step();
    vectors++; if (an !== 4'b1101) begin miscompares++; $display("FAIL unblank_an: got %b want 1101", an); end
  endtask

  task automatic test_reset_mid_scan();
    $display("test_reset_mid_scan");
    goto_state(9);
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (an !== 4'hF) begin miscompares++; $display("FAIL arst_an: got %b want 1111", an); end
    vectors++; if (seg !== 8'h00) begin miscompares++; $display("FAIL arst_seg: got %h want 00", seg); end
    vectors++; if (digit_idx !== 2'd0) begin miscompares++; $display("FAIL arst_idx: got %0d want 0", digit_idx); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL arst_fd: got %b want 0", frame_done); end
    vectors++; if (an_nh !== 4'hF || seg_nh !== 8'h00 || didx_nh !== 2'd0 || fd_nh !== 1'b0) begin
      miscompares++; $display("FAIL arst_nh: got an=%b seg=%h idx=%0d fd=%b", an_nh, seg_nh, didx_nh, fd_nh);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    goto_out(0, 2);
    vectors++; if (seg !== 8'hFC) begin miscompares++; $display("FAIL post_rst_d0: got %h want FC", seg); end
    vectors++; if (an !== 4'b1110) begin miscompares++; $display("FAIL post_rst_an0: got %b want 1110", an); end
    goto_state(4);
    do_load(16'h000C, 4'b0000);
    goto_state(0);
    goto_out(0, 2);
    vectors++; if (seg !== 8'h9C) begin miscompares++; $display("FAIL hex_C: got %h want 9C", seg); end
    vectors++; if (seg_nh !== 8'h02) begin miscompares++; $display("FAIL nohex_C: got %h want 02", seg_nh); end
    vectors++; if (an_nh !== 4'b1110) begin miscompares++; $display("FAIL nohex_an0: got %b want 1110", an_nh); end
  endtask

  initial begin
    test_reset();
    test_double_buffer();
    test_lz_blank();
    test_back_to_back();
    test_blank_in();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
